// File: rtl/pwr_seq.sv
// -----------------------------------------------------------------------------
// pwr_seq -- power-on / reset sequencer
//
// Brings the system out of reset in order:
//   WAIT_PLL -> RAM_RST -> WAIT_RAM -> SYS_RST -> RUN
// It then handles warm reset, cold reset, power-off and RAM failure from RUN.
// While the system PLL is unlocked, the block falls back to WAIT_PLL from
// every state except OFF and ERR.
//
// Parameters
//   RAMRSTCNTBITSZ : width of the RAM reset hold counter
//   RSTCNTBITSZ    : width of the system reset hold counter
//   TIMEOUTBITSZ   : width of the RAM-init timeout counter
//                    (used only when PWR_SEQ_RAMTIMEOUT_EN is defined)
//
// Optional feature
//   PWR_SEQ_RAMTIMEOUT_EN : when defined, WAIT_RAM gives up and goes to ERR
//                           once the timeout counter has expired.
//
// Ports
//   clk_i             : clock, rising edge
//   rst_n             : asynchronous active-low reset
//   pll_locked_i      : system PLL locked
//   ram_pll_locked_i  : DRAM-controller PLL locked
//   ram_init_done_i   : DRAM calibration finished
//   ram_init_error_i  : DRAM calibration failed
//   swrst0_i/swrst1_i : software reset request pair
//   cpu_rst_req_i     : reset request from the processor cluster
//   ram_rst_o         : DRAM controller / RAM cache reset
//   sys_rst_o         : interconnect / peripheral reset
//   cpu_rst_o         : processor cluster reset
//   cold_rst_o        : one-cycle global cold-reset pulse
//   off_o             : powered-off flag
//   err_o             : RAM failure flag
//   state_o           : current state encoding
// -----------------------------------------------------------------------------
module pwr_seq #(
  parameter int RAMRSTCNTBITSZ = 16,
  parameter int RSTCNTBITSZ    = 16,
  parameter int TIMEOUTBITSZ   = 24
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       ram_pll_locked_i,
  input  logic       ram_init_done_i,
  input  logic       ram_init_error_i,
  input  logic       swrst0_i,
  input  logic       swrst1_i,
  input  logic       cpu_rst_req_i,
  output logic       ram_rst_o,
  output logic       sys_rst_o,
  output logic       cpu_rst_o,
  output logic       cold_rst_o,
  output logic       off_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    WAIT_PLL = 3'd0,
    RAM_RST  = 3'd1,
    WAIT_RAM = 3'd2,
    SYS_RST  = 3'd3,
    RUN      = 3'd4,
    COLD     = 3'd5,
    OFF      = 3'd6,
    ERR      = 3'd7
  } state_e;

  state_e                      state_q, state_d;
  logic [RAMRSTCNTBITSZ-1:0]   ram_cnt_q, ram_cnt_d;
  logic [RSTCNTBITSZ-1:0]      sys_cnt_q, sys_cnt_d;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
  logic [TIMEOUTBITSZ-1:0]     to_cnt_q, to_cnt_d;
`endif

  logic ram_rst_q, ram_rst_d;
  logic sys_rst_q, sys_rst_d;
  logic cpu_rst_q, cpu_rst_d;
  logic cold_rst_q, cold_rst_d;
  logic off_q, off_d;
  logic err_q, err_d;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ram_cnt_d = ram_cnt_q;
    sys_cnt_d = sys_cnt_q;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif

    // Losing the system PLL beats every other transition, mid-count too.
    // OFF and ERR are sticky and only rst_n leaves them.
    if (!pll_locked_i && state_q != OFF && state_q != ERR) begin
      state_d   = WAIT_PLL;
      ram_cnt_d = '1;
      sys_cnt_d = '1;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
      to_cnt_d  = '1;
`endif
    end else begin
      unique case (state_q)
        WAIT_PLL: begin
          // PLL is known locked here (the branch above handles unlocked).
          state_d   = RAM_RST;
          ram_cnt_d = '1;
        end

        RAM_RST: begin
          if (ram_cnt_q == '0) begin
            state_d = WAIT_RAM;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
            to_cnt_d = '1;
`endif
          end else begin
            ram_cnt_d = ram_cnt_q - 1'b1;
          end
        end

        WAIT_RAM: begin
          // Calibration status is only trusted once the DRAM PLL is locked.
          // An error wins over done when both are set.
          if (ram_pll_locked_i && ram_init_error_i) begin
            state_d = ERR;
          end else if (ram_pll_locked_i && ram_init_done_i) begin
            state_d   = SYS_RST;
            sys_cnt_d = '1;
          end
`ifdef PWR_SEQ_RAMTIMEOUT_EN
          // Done/error above take precedence over an expiring timeout.
          else if (to_cnt_q == '0) begin
            state_d = ERR;
          end else begin
            to_cnt_d = to_cnt_q - 1'b1;
          end
`endif
        end

        SYS_RST: begin
          if (sys_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            sys_cnt_d = sys_cnt_q - 1'b1;
          end
        end

        RUN: begin
          if (swrst0_i && swrst1_i) begin
            state_d = COLD;
          end else if (swrst0_i) begin
            state_d = OFF;
          end else if (swrst1_i || cpu_rst_req_i) begin
            // Warm reset: RAM stays out of reset, only the system is cycled.
            state_d   = SYS_RST;
            sys_cnt_d = '1;
          end
        end

        COLD:    state_d = WAIT_PLL;
        OFF:     state_d = OFF;
        ERR:     state_d = ERR;
        default: state_d = WAIT_PLL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so the flops hold the value that
  // matches state_q on the same cycle. No input reaches an output without
  // passing through a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_rst_d  = (state_d == WAIT_PLL) || (state_d == RAM_RST) ||
                 (state_d == COLD)     || (state_d == OFF);
    sys_rst_d  = (state_d != RUN);
    // cpu_rst releases one cycle after sys_rst: the CPU comes out of reset
    // only on the second consecutive RUN cycle. It reasserts on the same edge
    // as sys_rst when RUN is left.
    cpu_rst_d  = !((state_d == RUN) && (state_q == RUN));
    cold_rst_d = (state_d == COLD);
    off_d      = (state_d == OFF);
    err_d      = (state_d == ERR);
  end

  // ---------------------------------------------------------------------------
  // State, counters and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_PLL;
      ram_cnt_q  <= '1;
      sys_cnt_q  <= '1;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
      to_cnt_q   <= '1;
`endif
      ram_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      cpu_rst_q  <= 1'b1;
      cold_rst_q <= 1'b0;
      off_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_cnt_q  <= ram_cnt_d;
      sys_cnt_q  <= sys_cnt_d;
`ifdef PWR_SEQ_RAMTIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
      ram_rst_q  <= ram_rst_d;
      sys_rst_q  <= sys_rst_d;
      cpu_rst_q  <= cpu_rst_d;
      cold_rst_q <= cold_rst_d;
      off_q      <= off_d;
      err_q      <= err_d;
    end
  end

  assign ram_rst_o  = ram_rst_q;
  assign sys_rst_o  = sys_rst_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign cold_rst_o = cold_rst_q;
  assign off_o      = off_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_pwr_seq -- directed self-checking bench for pwr_seq
// Small counters (RAM 3 bits, system 4 bits, timeout 5 bits) keep the run
// short: RAM_RST lasts 8 cycles, SYS_RST 16 cycles, and the timeout expires
// 32 cycles after WAIT_RAM entry.
// -----------------------------------------------------------------------------
module tb_pwr_seq;

  logic       clk_i;
  logic       rst_n;
  logic       pll_locked_i;
  logic       ram_pll_locked_i;
  logic       ram_init_done_i;
  logic       ram_init_error_i;
  logic       swrst0_i;
  logic       swrst1_i;
  logic       cpu_rst_req_i;
  logic       ram_rst_o;
  logic       sys_rst_o;
  logic       cpu_rst_o;
  logic       cold_rst_o;
  logic       off_o;
  logic       err_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  pwr_seq #(
    .RAMRSTCNTBITSZ(3),
    .RSTCNTBITSZ   (4),
    .TIMEOUTBITSZ  (5)
  ) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .pll_locked_i    (pll_locked_i),
    .ram_pll_locked_i(ram_pll_locked_i),
    .ram_init_done_i (ram_init_done_i),
    .ram_init_error_i(ram_init_error_i),
    .swrst0_i        (swrst0_i),
    .swrst1_i        (swrst1_i),
    .cpu_rst_req_i   (cpu_rst_req_i),
    .ram_rst_o       (ram_rst_o),
    .sys_rst_o       (sys_rst_o),
    .cpu_rst_o       (cpu_rst_o),
    .cold_rst_o      (cold_rst_o),
    .off_o           (off_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Assert rst_n mid-cycle, check the asynchronous reset values, release on
  // a falling edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_state"}, state_o, 0);
    check({tag, "_ram"},   ram_rst_o, 1);
    check({tag, "_sys"},   sys_rst_o, 1);
    check({tag, "_cpu"},   cpu_rst_o, 1);
    check({tag, "_cold"},  cold_rst_o, 0);
    check({tag, "_off"},   off_o, 0);
    check({tag, "_err"},   err_o, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  // From a reset release with PLL locked: 1 edge into RAM_RST, 8 in RAM_RST.
  task automatic to_wait_ram(input string tag);
    tick(9);
    check({tag, "_wait_ram"}, state_o, 2);
  endtask

  // From WAIT_RAM: done -> SYS_RST, 16 cycles, RUN, then cpu release.
  task automatic to_run(input string tag);
    ram_init_done_i = 1'b1;
    tick(1);
    ram_init_done_i = 1'b0;
    check({tag, "_sys_rst"}, state_o, 3);
    tick(16);
    check({tag, "_run"}, state_o, 4);
    tick(1);
    check({tag, "_cpu_rel"}, cpu_rst_o, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    pll_locked_i     = 1'b1;
    ram_pll_locked_i = 1'b1;
    ram_init_done_i  = 1'b0;
    ram_init_error_i = 1'b0;
    swrst0_i         = 1'b0;
    swrst1_i         = 1'b0;
    cpu_rst_req_i    = 1'b0;

    // ---- reset values and cold boot ----------------------------------------
    #12;
    pulse_reset("rst0");
    tick(1);
    check("boot_ram_rst_state", state_o, 1);
    check("boot_ram_rst_hold", ram_rst_o, 1);
    // Requests outside RUN must be ignored.
    swrst0_i = 1'b1;
    tick(7);
    swrst0_i = 1'b0;
    check("boot_ram_rst_last", state_o, 1);
    check("boot_ram_rst_still1", ram_rst_o, 1);
    tick(1);
    check("boot_wait_ram_state", state_o, 2);
    check("boot_ram_rst_fall", ram_rst_o, 0);
    check("boot_sys_rst_held", sys_rst_o, 1);
    tick(3);
    ram_init_done_i = 1'b1;
    tick(1);
    ram_init_done_i = 1'b0;
    check("boot_sys_rst_state", state_o, 3);
    tick(15);
    check("boot_sys_rst_last", state_o, 3);
    check("boot_sys_rst_still1", sys_rst_o, 1);
    tick(1);
    check("boot_run_state", state_o, 4);
    check("boot_sys_rst_fall", sys_rst_o, 0);
    check("boot_cpu_rst_lag", cpu_rst_o, 1);
    tick(1);
    check("boot_cpu_rst_fall", cpu_rst_o, 0);

    // ---- warm reset via swrst1 ---------------------------------------------
    swrst1_i = 1'b1;
    tick(1);
    swrst1_i = 1'b0;
    check("warm_state", state_o, 3);
    check("warm_ram_rst", ram_rst_o, 0);
    check("warm_sys_rst", sys_rst_o, 1);
    check("warm_cpu_rst", cpu_rst_o, 1);
    tick(15);
    check("warm_hold", state_o, 3);
    tick(1);
    check("warm_run", state_o, 4);
    tick(1);

    // ---- cold software reset, then lock loss in RAM_RST --------------------
    swrst0_i = 1'b1;
    swrst1_i = 1'b1;
    tick(1);
    swrst0_i = 1'b0;
    swrst1_i = 1'b0;
    check("cold_state", state_o, 5);
    check("cold_pulse", cold_rst_o, 1);
    check("cold_ram_rst", ram_rst_o, 1);
    tick(1);
    check("cold_to_pll", state_o, 0);
    check("cold_pulse_end", cold_rst_o, 0);
    tick(1);
    check("cold_ram_rst_state", state_o, 1);
    tick(3);
    pll_locked_i = 1'b0;
    tick(1);
    check("lock_loss_state", state_o, 0);
    tick(2);
    check("lock_loss_wait", state_o, 0);
    pll_locked_i = 1'b1;
    tick(1);
    check("relock_ram_rst", state_o, 1);
    tick(7);
    check("relock_full_hold", state_o, 1);
    tick(1);
    check("relock_wait_ram", state_o, 2);

    // ---- RAM failure: error wins over done ---------------------------------
    ram_init_done_i  = 1'b1;
    ram_init_error_i = 1'b1;
    tick(1);
    ram_init_done_i  = 1'b0;
    ram_init_error_i = 1'b0;
    check("err_state", state_o, 7);
    check("err_flag", err_o, 1);
    check("err_ram_rst", ram_rst_o, 0);
    check("err_sys_rst", sys_rst_o, 1);
    pll_locked_i = 1'b0;
    tick(2);
    check("err_sticky", state_o, 7);
    pll_locked_i = 1'b1;
    pulse_reset("rst1");

    // ---- cpu request warm reset, lock loss in RUN, then power-off ----------
    to_wait_ram("b2");
    to_run("b2");
    cpu_rst_req_i = 1'b1;
    tick(1);
    cpu_rst_req_i = 1'b0;
    check("cpureq_state", state_o, 3);
    tick(16);
    check("cpureq_run", state_o, 4);
    pll_locked_i = 1'b0;
    tick(1);
    pll_locked_i = 1'b1;
    check("run_lock_loss", state_o, 0);
    check("run_lock_loss_sys", sys_rst_o, 1);
    tick(1);
    to_wait_ram("b3");
    to_run("b3");
    swrst0_i = 1'b1;
    tick(1);
    swrst0_i = 1'b0;
    check("off_state", state_o, 6);
    check("off_flag", off_o, 1);
    check("off_ram_rst", ram_rst_o, 1);
    check("off_sys_rst", sys_rst_o, 1);
    check("off_cpu_rst", cpu_rst_o, 1);
    pll_locked_i = 1'b0;
    tick(2);
    pll_locked_i = 1'b1;
    tick(2);
    check("off_sticky", state_o, 6);
    check("off_sticky_flag", off_o, 1);
    pulse_reset("rst2");

    // ---- RAM-init timeout ----------------------------------------------------
    to_wait_ram("b4");
`ifdef PWR_SEQ_RAMTIMEOUT_EN
    tick(31);
    check("to_before", state_o, 2);
    tick(1);
    check("to_expire", state_o, 7);
    check("to_err_flag", err_o, 1);
`else
    tick(1000);
    check("no_timeout", state_o, 2);
    check("no_timeout_err", err_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
